// File: rtl/uart_fifo_io_pkg.sv
// uart_fifo_io_pkg
// Shared definitions for the bus-mapped UART: register addresses on the
// 3-bit CPU address bus, bit positions inside the status register and the
// state encodings of the transmit and receive bit engines.
package uart_fifo_io_pkg;

    // Register addresses
    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_PRE_HI   = 3'd2;
    localparam logic [2:0] REG_PRE_LO   = 3'd3;
    localparam logic [2:0] REG_RX_COUNT = 3'd4;
    localparam logic [2:0] REG_TX_COUNT = 3'd5;
    localparam logic [2:0] REG_RX_THR   = 3'd6;
    localparam logic [2:0] REG_ZERO     = 3'd7;

    // Status register bit positions
    localparam int ST_RNE = 0;
    localparam int ST_RFE = 1;
    localparam int ST_ROE = 2;
    localparam int ST_TXF = 3;
    localparam int ST_RIE = 4;
    localparam int ST_TIE = 5;
    localparam int ST_RIQ = 6;
    localparam int ST_TIQ = 7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_fifo_io_fifo.sv
// uart_sync_fifo
// Single-clock FIFO used for both the RX and TX queues of uart_fifo_io.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   push, push_data   write request and data (dropped when full unless a
//                     pop happens in the same cycle)
//   pop               read request (ignored when empty)
//   head_data         current head entry, combinational
//   full, empty       occupancy flags
//   count             number of entries, one bit wider than the pointers so
//                     that a completely full FIFO is representable
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_ok    = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok   = push & (~full | pop_ok);
    assign head_data = mem[rd_ptr];

    // Storage array; no reset needed since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_io.sv
// uart_fifo_io
// Bus-mapped UART with RX/TX FIFOs and its own bit engines running on clk.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   AD, DI     register address and write data
//   DO         registered read data, valid the cycle after cs & rw
//   rw, cs     1 = read / 0 = write, one-cycle access strobe
//   irq        registered level interrupt (RIQ | TIQ)
//   rxd        asynchronous serial input
//   txd        serial output, idle high
module uart_fifo_io
    import uart_fifo_io_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter int          DATA_BITS    = 8,
    parameter int          STOP_BITS    = 1,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       rxd,
    output logic       txd
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic                 rd_en, wr_en;
    logic [7:0]           rd_data;
    logic [15:0]          prescaler;
    logic [7:0]           rx_thr;
    logic [8:0]           thr_eff;
    logic                 tie, rie, roe, rfe;
    logic                 riq, tiq;

    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic [CW-1:0]        tx_count;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_head;
    logic [CW-1:0]        rx_count;

    tx_state_t            tx_state, tx_state_n;
    logic [15:0]          tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bits, tx_bits_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 txd_n, tx_bit_done;

    rx_state_t            rx_state, rx_state_n;
    logic [15:0]          rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bits, rx_bits_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_armed, rx_armed_n;
    logic                 rx_meta, rx_sync, rx_bit_done;
    logic [16:0]          rx_half;
    logic                 roe_set, rfe_set;

    assign rd_en   = cs & rw;
    assign wr_en   = cs & ~rw;
    assign tx_push = wr_en & (AD == REG_DATA);
    assign rx_pop  = rd_en & (AD == REG_DATA) & ~rx_empty;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (DI[DATA_BITS-1:0]),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // A threshold of zero would fire with an empty FIFO, so it acts as one
    assign thr_eff = (rx_thr == 8'd0) ? 9'd1 : {1'b0, rx_thr};
    assign riq     = rie & (16'(rx_count) >= 16'(thr_eff));
    assign tiq     = tie & tx_empty & (tx_state == TX_IDLE);

    // Read data mux; registered into DO only on a read strobe
    always_comb begin
        rd_data = 8'd0;
        case (AD)
            REG_DATA: begin
                if (!rx_empty) begin
                    rd_data = 8'(rx_head);
                end
            end
            REG_STATUS: begin
                rd_data[ST_TIQ] = tiq;
                rd_data[ST_RIQ] = riq;
                rd_data[ST_TIE] = tie;
                rd_data[ST_RIE] = rie;
                rd_data[ST_TXF] = tx_full;
                rd_data[ST_ROE] = roe;
                rd_data[ST_RFE] = rfe;
                rd_data[ST_RNE] = ~rx_empty;
            end
            REG_PRE_HI:   rd_data = prescaler[15:8];
            REG_PRE_LO:   rd_data = prescaler[7:0];
            REG_RX_COUNT: rd_data = 8'(rx_count);
            REG_TX_COUNT: rd_data = 8'(tx_count);
            REG_RX_THR:   rd_data = rx_thr;
            default:      rd_data = 8'd0;
        endcase
    end

    // CPU-visible control registers, read-data register and irq register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= PRESCALE_RST;
            rx_thr    <= 8'd1;
            tie       <= 1'b0;
            rie       <= 1'b0;
            DO        <= 8'd0;
            irq       <= 1'b0;
        end else begin
            irq <= riq | tiq;
            if (rd_en) begin
                DO <= rd_data;
            end
            if (wr_en) begin
                case (AD)
                    REG_STATUS: begin
                        tie <= DI[5];
                        rie <= DI[4];
                    end
                    REG_PRE_HI: prescaler[15:8] <= DI;
                    REG_PRE_LO: prescaler[7:0]  <= DI;
                    REG_RX_THR: rx_thr          <= DI;
                    default: ;
                endcase
            end
        end
    end

    // Sticky error flags: an engine set beats a CPU clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            roe <= 1'b0;
            rfe <= 1'b0;
        end else begin
            if (roe_set) begin
                roe <= 1'b1;
            end else if (wr_en && (AD == REG_STATUS) && DI[2]) begin
                roe <= 1'b0;
            end
            if (rfe_set) begin
                rfe <= 1'b1;
            end else if (wr_en && (AD == REG_STATUS) && DI[1]) begin
                rfe <= 1'b0;
            end
        end
    end

    // ---------------- Transmit engine ----------------
    // ">=" rather than "==" so shrinking the prescaler mid-bit cannot hang
    assign tx_bit_done = (tx_cnt >= prescaler);

    // TX state register; txd is registered and returns high on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_bits  <= 3'd0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
        end
    end

    // TX next state; the end of the last stop bit fetches the next byte
    // directly so back-to-back frames have no idle gap
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = 16'd0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_cnt_n   = 16'd0;
                    tx_bits_n  = 3'd0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    tx_cnt_n   = 16'd0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bits == LAST_DATA) begin
                        tx_bits_n  = 3'd0;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bits_n = tx_bits + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_done) begin
                    tx_cnt_n = 16'd0;
                    if (tx_bits == LAST_STOP) begin
                        tx_bits_n = 3'd0;
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_n = tx_head;
                            tx_state_n = TX_START;
                        end else begin
                            tx_state_n = TX_IDLE;
                        end
                    end else begin
                        tx_bits_n = tx_bits + 3'd1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_shift_n[0];
            default:  txd_n = 1'b1;
        endcase
    end

    // ---------------- Receive engine ----------------
    assign rx_bit_done = (rx_cnt >= prescaler);
    assign rx_half     = (17'(prescaler) + 17'd1) >> 1;

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bits  <= 3'd0;
            rx_shift <= '0;
            rx_armed <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bits  <= rx_bits_n;
            rx_shift <= rx_shift_n;
            rx_armed <= rx_armed_n;
        end
    end

    // RX next state; IDLE only re-arms after seeing the line high, so a
    // frame ending on a low stop bit cannot immediately retrigger
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_bits_n  = rx_bits;
        rx_shift_n = rx_shift;
        rx_armed_n = rx_armed;
        rx_push    = 1'b0;
        roe_set    = 1'b0;
        rfe_set    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = 16'd0;
                if (!rx_armed) begin
                    if (rx_sync) begin
                        rx_armed_n = 1'b1;
                    end
                end else if (!rx_sync) begin
                    rx_armed_n = 1'b0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if ((17'(rx_cnt) + 17'd1) >= rx_half) begin
                    rx_cnt_n   = 16'd0;
                    rx_bits_n  = 3'd0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_done) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bits == LAST_DATA) begin
                        rx_bits_n  = 3'd0;
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bits_n = rx_bits + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_bit_done) begin
                    rx_cnt_n   = 16'd0;
                    rx_state_n = RX_IDLE;
                    if (rx_sync) begin
                        rx_push = 1'b1;
                        roe_set = rx_full & ~rx_pop;
                    end else begin
                        rfe_set = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_io.sv
// tb_uart_fifo_io
// Directed bench for uart_fifo_io built with FIFO_DEPTH=4, 8 data bits,
// one stop bit. Each scenario task drives the bus/serial line and compares
// observed values against hand-computed expectations.
module tb_uart_fifo_io;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       rxd;
    logic       txd;
    logic       rxd_drv;
    logic       loop_en;

    int checks   = 0;
    int failures = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_fifo_io #(
        .FIFO_DEPTH   (4),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PRESCALE_RST (16'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs),
        .irq (irq),
        .rxd (rxd),
        .txd (txd)
    );

    always #5 clk = ~clk;

    // Single-cycle bus write, driven on the falling edge
    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    // Single-cycle bus read; DO is registered, so it is valid one edge later
    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
        @(negedge clk);
        cs = 1'b0;
        d = DO;
    endtask

    // Serial frame into rxd at 16 clocks per bit (prescaler 15)
    task automatic send_rx_frame(input logic [7:0] b, input logic stop_val);
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (16) @(negedge clk);
        end
        rxd_drv = stop_val;
        repeat (16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2:0] addrs [9];
        logic [7:0] exps  [9];
        logic [7:0] v;
        addrs = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd7};
        exps  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'd0;
        rxd_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (DO !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_DO: got %h expected 00", DO);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        checks++;
        if (txd !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_txd: got %b expected 1", txd);
        end
        rst = 1'b0;
        @(negedge clk);
        // Writes to read-only addresses must be ignored
        cpu_write(3'd4, 8'hFF);
        cpu_write(3'd7, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            cpu_read(addrs[i], v);
            checks++;
            if (v !== exps[i]) begin
                failures++;
                $display("[TB] FAIL reset_reg%0d: got %h expected %h", addrs[i], v, exps[i]);
            end
        end
    endtask

    task automatic test_tx_frame();
        logic [7:0] tx_byte;
        logic       expv;
        logic       bad;
        logic       got;
        logic [7:0] v;
        tx_byte = 8'h55;
        cpu_write(3'd2, 8'h00);
        cpu_write(3'd3, 8'h09);
        cpu_write(3'd1, 8'h20);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("[TB] FAIL tx_idle_tiq: irq got %b expected 1", irq);
        end
        cpu_write(3'd0, tx_byte);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (txd === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++; $display("[TB] FAIL tx_start_seen: txd got %b expected 0 within 50 clks", txd);
        end else begin
            for (int k = 0; k < 10; k++) begin
                expv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_byte[k-1];
                bad  = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    if (!(k == 0 && c == 0)) @(negedge clk);
                    if (txd !== expv) bad = 1'b1;
                end
                checks++;
                if (bad) begin
                    failures++; $display("[TB] FAIL tx_bit%0d: txd not held at %b for 10 clks", k, expv);
                end
                if (k == 5) begin
                    checks++;
                    if (irq !== 1'b0) begin
                        failures++; $display("[TB] FAIL tx_busy_irq: got %b expected 0", irq);
                    end
                end
            end
            repeat (3) @(negedge clk);
            checks++;
            if (irq !== 1'b1 || txd !== 1'b1) begin
                failures++; $display("[TB] FAIL tx_done_irq: irq=%b txd=%b expected 1/1", irq, txd);
            end
            cpu_read(3'd1, v);
            checks++;
            if (v !== 8'hA0) begin
                failures++; $display("[TB] FAIL tx_done_status: got %h expected a0", v);
            end
        end
        cpu_write(3'd1, 8'h00);
    endtask

    // Six quick writes at depth 4: the first byte goes straight into the
    // engine, the next four fill the FIFO and the sixth is dropped
    task automatic test_back_to_back();
        logic [7:0] v;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    cpu_write(3'd0, 8'((i + 1) * 17));
                end
                cpu_read(3'd5, v);
                checks++;
                if (v !== 8'd4) begin
                    failures++; $display("[TB] FAIL b2b_txcount: got %0d expected 4", v);
                end
                cpu_read(3'd1, v);
                checks++;
                if (v !== 8'h08) begin
                    failures++; $display("[TB] FAIL b2b_txf: got %h expected 08", v);
                end
            end
            begin
                logic       got;
                logic       bad;
                logic [7:0] rb;
                got = 1'b0;
                for (int n = 0; n < 50 && !got; n++) begin
                    @(negedge clk);
                    if (txd === 1'b0) got = 1'b1;
                end
                checks++;
                if (!got) begin
                    failures++; $display("[TB] FAIL b2b_start_seen: txd got %b expected 0 within 50 clks", txd);
                end else begin
                    for (int f = 0; f < 5; f++) begin
                        rb  = 8'h00;
                        bad = 1'b0;
                        for (int c = 1; c < 100; c++) begin
                            @(negedge clk);
                            if (c == 5 && txd !== 1'b0) bad = 1'b1;
                            if (c >= 15 && c <= 85 && (c % 10) == 5) rb[(c - 15) / 10] = txd;
                            if (c == 95 && txd !== 1'b1) bad = 1'b1;
                        end
                        checks++;
                        if (rb !== 8'((f + 1) * 17) || bad) begin
                            failures++;
                            $display("[TB] FAIL b2b_frame%0d: got %h framing_bad=%b expected %h", f, rb, bad, 8'((f + 1) * 17));
                        end
                        @(negedge clk);
                        checks++;
                        if (txd !== ((f < 4) ? 1'b0 : 1'b1)) begin
                            failures++;
                            $display("[TB] FAIL b2b_gap%0d: txd got %b expected %b", f, txd, (f < 4) ? 1'b0 : 1'b1);
                        end
                    end
                    bad = 1'b0;
                    for (int c = 0; c < 150; c++) begin
                        @(negedge clk);
                        if (txd !== 1'b1) bad = 1'b1;
                    end
                    checks++;
                    if (bad) begin
                        failures++; $display("[TB] FAIL b2b_dropped: txd went low, expected idle high");
                    end
                end
            end
        join
        cpu_read(3'd5, v);
        checks++;
        if (v !== 8'd0) begin
            failures++; $display("[TB] FAIL b2b_txcount_end: got %0d expected 0", v);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        logic [7:0] expb [3];
        logic       got;
        expb = '{8'hA1, 8'h02, 8'h7F};
        loop_en = 1'b1;
        cpu_write(3'd3, 8'd15);
        cpu_write(3'd6, 8'd3);
        cpu_write(3'd1, 8'h10);
        cpu_write(3'd0, 8'hA1);
        cpu_write(3'd0, 8'h02);
        repeat (400) @(negedge clk);
        cpu_read(3'd4, v);
        checks++;
        if (v !== 8'd2) begin
            failures++; $display("[TB] FAIL loop_count2: got %0d expected 2", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("[TB] FAIL loop_irq_below_thr: got %b expected 0", irq);
        end
        cpu_write(3'd0, 8'h7F);
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (irq === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++; $display("[TB] FAIL loop_irq_at_thr: irq got %b expected 1 within 300 clks", irq);
        end
        cpu_read(3'd4, v);
        checks++;
        if (v !== 8'd3) begin
            failures++; $display("[TB] FAIL loop_count3: got %0d expected 3", v);
        end
        for (int i = 0; i < 3; i++) begin
            cpu_read(3'd0, v);
            checks++;
            if (v !== expb[i]) begin
                failures++; $display("[TB] FAIL loop_data%0d: got %h expected %h", i, v, expb[i]);
            end
            if (i == 0) begin
                @(negedge clk);
                checks++;
                if (irq !== 1'b0) begin
                    failures++; $display("[TB] FAIL loop_irq_drop: got %b expected 0", irq);
                end
            end
        end
        cpu_read(3'd0, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("[TB] FAIL loop_empty_read: got %h expected 00", v);
        end
        cpu_write(3'd1, 8'h00);
        loop_en = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        for (int i = 0; i < 5; i++) begin
            send_rx_frame(8'(8'h31 + i), 1'b1);
        end
        cpu_read(3'd4, v);
        checks++;
        if (v !== 8'd4) begin
            failures++; $display("[TB] FAIL ovr_count: got %0d expected 4", v);
        end
        cpu_read(3'd1, v);
        checks++;
        if (v !== 8'h05) begin
            failures++; $display("[TB] FAIL ovr_roe_set: got %h expected 05", v);
        end
        cpu_write(3'd1, 8'h04);
        cpu_read(3'd1, v);
        checks++;
        if (v !== 8'h01) begin
            failures++; $display("[TB] FAIL ovr_roe_clear: got %h expected 01", v);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(3'd0, v);
            checks++;
            if (v !== 8'(8'h31 + i)) begin
                failures++; $display("[TB] FAIL ovr_data%0d: got %h expected %h", i, v, 8'(8'h31 + i));
            end
        end
        cpu_read(3'd4, v);
        checks++;
        if (v !== 8'd0) begin
            failures++; $display("[TB] FAIL ovr_count_end: got %0d expected 0", v);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] v;
        send_rx_frame(8'h3C, 1'b1);
        send_rx_frame(8'h5A, 1'b0);
        cpu_read(3'd4, v);
        checks++;
        if (v !== 8'd1) begin
            failures++; $display("[TB] FAIL fe_count: got %0d expected 1", v);
        end
        cpu_read(3'd1, v);
        checks++;
        if (v !== 8'h03) begin
            failures++; $display("[TB] FAIL fe_rfe_set: got %h expected 03", v);
        end
        cpu_write(3'd1, 8'h02);
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        cpu_read(3'd4, v);
        checks++;
        if (v !== 8'd1) begin
            failures++; $display("[TB] FAIL glitch_count: got %0d expected 1", v);
        end
        cpu_read(3'd1, v);
        checks++;
        if (v !== 8'h01) begin
            failures++; $display("[TB] FAIL glitch_flags: got %h expected 01", v);
        end
        cpu_read(3'd0, v);
        checks++;
        if (v !== 8'h3C) begin
            failures++; $display("[TB] FAIL fe_good_byte: got %h expected 3c", v);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] v;
        logic       got;
        logic       bad;
        cpu_read(3'd6, v);
        checks++;
        if (v !== 8'd3) begin
            failures++; $display("[TB] FAIL mid_thr_before: got %0d expected 3", v);
        end
        cpu_write(3'd0, 8'h00);
        cpu_write(3'd0, 8'h00);
        cpu_write(3'd0, 8'h81);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (txd === 1'b0) got = 1'b1;
        end
        repeat (40) @(negedge clk);
        checks++;
        if (!got || txd !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_tx_low: txd got %b expected 0 mid-frame", txd);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || DO !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_async: txd=%b DO=%h irq=%b expected 1/00/0", txd, DO, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        cpu_read(3'd5, v);
        checks++;
        if (v !== 8'd0) begin
            failures++; $display("[TB] FAIL mid_txcount: got %0d expected 0", v);
        end
        cpu_read(3'd6, v);
        checks++;
        if (v !== 8'd1) begin
            failures++; $display("[TB] FAIL mid_thr_reset: got %0d expected 1", v);
        end
        cpu_read(3'd3, v);
        checks++;
        if (v !== 8'd0) begin
            failures++; $display("[TB] FAIL mid_prescale_reset: got %0d expected 0", v);
        end
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("[TB] FAIL mid_tx_flushed: txd went low, expected idle high");
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_overrun();
        test_frame_error();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
